soc_data_responder: RTL and testbench
=====================================

# soc_data_responder

Slave (responder) end of the core data-memory interface in `zeroriscy_soc`. It accepts the core's `req`/`gnt`/`rvalid` data transactions and serves them from a word-addressed on-chip RAM with byte enables and a programmable number of wait states. It also decodes two mailbox addresses: software writes to them to drive the `mem_flag` and `mem_result` observables that benches monitor.

## Interface
- `DEPTH_LOG2`, default 10: RAM holds 2^DEPTH_LOG2 32-bit words; base address is 0x0000_0000.
- `WAIT_CYCLES`, default 0: cycles from `req` to `gnt` (0 to 15).
- `FLAG_ADDR`, default 32'h0001_0000: byte address of the flag mailbox.
- `RESULT_ADDR`, default 32'h0001_0004: byte address of the result mailbox.
- `clk_i` input 1: the single clock. All state is on the rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `data_req_i` input 1: core request.
- `data_addr_i` input 32: byte address. Bits [1:0] are ignored.
- `data_we_i` input 1: 1 = write, 0 = read.
- `data_be_i` input 4: byte enables. Bit n enables byte lane n.
- `data_wdata_i` input 32: write data.
- `data_gnt_o` output 1: request accepted. Address and control are sampled in this cycle.
- `data_rvalid_o` output 1: response valid, for one cycle.
- `data_rdata_o` output 32: read data. Valid only while `rvalid` is high.
- `data_err_o` output 1: error response. Qualified by `rvalid`.
- `mem_flag_o` output 32: flag mailbox register.
- `mem_result_o` output 32: result mailbox register.

## Operation
- States: IDLE, WAIT, RESP.
- At most one transaction is outstanding.
- IDLE:
  - If `req`=1 and WAIT_CYCLES=0: assert `gnt` combinationally in the same cycle, perform the access, go to RESP.
  - If `req`=1 and WAIT_CYCLES>0: load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT:
  - `gnt` is asserted when the counter is 0 and `req`=1. Perform the access, go to RESP.
  - Otherwise the counter decrements.
  - If `req` drops in WAIT (protocol violation): return to IDLE. No access is performed and no response is issued.
- RESP:
  - `rvalid`=1 for exactly one cycle.
  - A new `req` in this cycle is handled with the same rules as IDLE. This gives back-to-back accesses with no bubble when WAIT_CYCLES=0.
  - If there is no new `req`, go to IDLE.
- Address decode, done at grant time:
  - RAM: word index `addr[DEPTH_LOG2+1:2]`, valid when `addr < 4*2^DEPTH_LOG2`.
  - FLAG_ADDR and RESULT_ADDR hit the mailboxes.
  - Any other address is out of range.
- Write: only the byte lanes with `be` set are updated, in the RAM word or mailbox register. `rdata`=0 in the response.
- Read: the full 32-bit word, registered into `rdata` for the RESP cycle. `be` is ignored on reads.
- Out of range: `err`=1 in the RESP cycle, `rdata`=0, no state change.
- Mailboxes read back their current value. A write with `be`=0 is a legal no-op with a normal response.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, counter=0, `gnt`=0, `rvalid`=0, `err`=0, `rdata`=0, `mem_flag_o`=0, `mem_result_o`=0.
- RAM contents are not reset.
- Latency from `req` to `rvalid`: WAIT_CYCLES+1 cycles. `gnt` appears in cycle WAIT_CYCLES; `rvalid` appears in cycle WAIT_CYCLES+1.
- Mailbox outputs change on the clock edge that ends the granted cycle. They are visible in the RESP cycle.
- A read granted in the cycle after a write to the same word returns the new data. There is no read-during-write hazard because accesses are serialized.
- Reset asserted mid-transaction (WAIT or RESP): the transaction is abandoned and no `rvalid` follows.
  - A write already granted has already committed.
- `gnt` never asserts when `req`=0.
- `rvalid` never asserts without a prior `gnt`.

## Structure
- Shared package `soc_pkg`:
  - state enum `resp_state_e` (IDLE, WAIT, RESP);
  - the default mailbox address constants;
  - a `be_merge` function (old word, new word, be → merged word).
- One sub-module, `soc_ram_be`: single-port RAM with byte-lane write enables and a registered read.
  - The responder FSM, counter, decode and mailboxes live in the top.

## Test plan
- WAIT_CYCLES=0; write 0xDEADBEEF to 0x10 with be=4'hF, then read 0x10 → `gnt` in the same cycle as `req`, `rvalid` one cycle later, read `rdata`=0xDEADBEEF, `err`=0.
- Byte lanes: write 0x11223344 to 0x20 with be=F, then 0xAABBCCDD with be=4'b0101, read back → 0x11BB33DD.
- WAIT_CYCLES=3; hold `req` on a read → `gnt` in cycle 3, `rvalid` in cycle 4. Second run drops `req` in cycle 1 → no `gnt`, no `rvalid`, FSM back in IDLE.
- Back-to-back: four reads with `req` held high across the RESP cycles, WAIT_CYCLES=0 → one `rvalid` per cycle, data returned in order.
- Mailbox: write 55 to RESULT_ADDR, then 1 to FLAG_ADDR → `mem_result_o`=55 and `mem_flag_o`=1, each visible in its RESP cycle. Reading back FLAG_ADDR returns 1.
- Error and reset:
  - Read of 0x8000_0000 → `rvalid`=1, `err`=1, `rdata`=0.
  - `rst_i` pulse during WAIT → all outputs 0 immediately, no `rvalid` afterwards.

Source files
------------

// File: rtl/soc_pkg.sv
// -----------------------------------------------------------------------------
// soc_pkg
// Shared types and helpers for the core data-memory responder.
//   resp_state_e    : responder FSM states (IDLE, WAIT, RESP)
//   DEF_FLAG_ADDR   : default byte address of the flag mailbox
//   DEF_RESULT_ADDR : default byte address of the result mailbox
//   be_merge()      : byte-lane merge of a new word into an old word
// -----------------------------------------------------------------------------
package soc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } resp_state_e;

   localparam logic [31:0] DEF_FLAG_ADDR   = 32'h0001_0000;
   localparam logic [31:0] DEF_RESULT_ADDR = 32'h0001_0004;

   // Lane n of the result comes from new_w when be[n] is set, else from old_w.
   function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
      logic [31:0] m;
      m = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
      end
      return m;
   endfunction

endpackage

// File: rtl/soc_ram_be.sv
// -----------------------------------------------------------------------------
// soc_ram_be
// Single-port word RAM with byte-lane write enables and a registered read.
//   clk_i   : clock
//   en_i    : access enable (one access per asserted cycle)
//   we_i    : 1 = write, 0 = read
//   addr_i  : word index
//   be_i    : byte-lane write enables (ignored on reads)
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after a read access
// Contents and the read register are deliberately not reset.
// -----------------------------------------------------------------------------
module soc_ram_be
   import soc_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk_i,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] addr_i,
   input  logic [3:0]            be_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   logic [31:0] r_mem [2**DEPTH_LOG2];
   logic [31:0] r_rdata;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) r_mem[addr_i] <= be_merge(r_mem[addr_i], wdata_i, be_i);
         else      r_rdata       <= r_mem[addr_i];
      end
   end

   assign rdata_o = r_rdata;

endmodule

// File: rtl/soc_data_responder.sv
// -----------------------------------------------------------------------------
// soc_data_responder
// Responder end of the core data interface (req/gnt/rvalid). Serves a
// word-addressed RAM at address 0 plus two write/readable mailbox registers.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   data_req_i       : core request
//   data_addr_i      : byte address ([1:0] ignored)
//   data_we_i        : 1 = write, 0 = read
//   data_be_i        : byte enables (writes only)
//   data_wdata_i     : write data
//   data_gnt_o       : request accepted this cycle (combinational)
//   data_rvalid_o    : one-cycle response strobe
//   data_rdata_o     : read data, zero outside the response cycle
//   data_err_o       : out-of-range response, qualified by rvalid
//   mem_flag_o       : flag mailbox
//   mem_result_o     : result mailbox
// -----------------------------------------------------------------------------
module soc_data_responder
   import soc_pkg::*;
#(
   parameter int          DEPTH_LOG2  = 10,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] FLAG_ADDR   = DEF_FLAG_ADDR,
   parameter logic [31:0] RESULT_ADDR = DEF_RESULT_ADDR
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic [31:0] mem_flag_o,
   output logic [31:0] mem_result_o
);

   localparam logic [32:0] RAM_BYTES = 33'd4 << DEPTH_LOG2;

   resp_state_e r_state;
   logic [3:0]  r_cnt;
   logic        r_err;
   logic        r_src_ram;   // response data comes from the RAM read port
   logic [31:0] r_mb_rdata;  // mailbox read data, zero for writes/errors
   logic [31:0] r_flag;
   logic [31:0] r_result;

   logic        w_gnt;
   logic        w_ram_hit;
   logic        w_flag_hit;
   logic        w_result_hit;
   logic [31:0] w_ram_rdata;

   // Address decode; RAM takes priority should a mailbox ever overlap it.
   assign w_ram_hit    = ({1'b0, data_addr_i} < RAM_BYTES);
   assign w_flag_hit   = !w_ram_hit && (data_addr_i[31:2] == FLAG_ADDR[31:2]);
   assign w_result_hit = !w_ram_hit && (data_addr_i[31:2] == RESULT_ADDR[31:2]);

   // Grant: immediately from IDLE/RESP when there are no wait states,
   // otherwise once the WAIT counter has run out. Held low during reset.
   always_comb begin
      w_gnt = 1'b0;
      if (data_req_i && !rst_i) begin
         if (r_state == WAIT) w_gnt = (r_cnt == 4'd0);
         else                 w_gnt = (WAIT_CYCLES == 0);
      end
   end

   soc_ram_be #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
      .clk_i   (clk_i),
      .en_i    (w_gnt && w_ram_hit),
      .we_i    (data_we_i),
      .addr_i  (data_addr_i[DEPTH_LOG2+1:2]),
      .be_i    (data_be_i),
      .wdata_i (data_wdata_i),
      .rdata_o (w_ram_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_err      <= 1'b0;
         r_src_ram  <= 1'b0;
         r_mb_rdata <= 32'd0;
         r_flag     <= 32'd0;
         r_result   <= 32'd0;
      end else if (w_gnt) begin
         // Granted cycle: perform the access, respond next cycle.
         r_state    <= RESP;
         r_err      <= !(w_ram_hit || w_flag_hit || w_result_hit);
         r_src_ram  <= w_ram_hit && !data_we_i;
         r_mb_rdata <= 32'd0;
         if (data_we_i) begin
            if (w_flag_hit)   r_flag   <= be_merge(r_flag, data_wdata_i, data_be_i);
            if (w_result_hit) r_result <= be_merge(r_result, data_wdata_i, data_be_i);
         end else begin
            if (w_flag_hit)        r_mb_rdata <= r_flag;
            else if (w_result_hit) r_mb_rdata <= r_result;
         end
      end else begin
         case (r_state)
            WAIT: begin
               // A dropped request abandons the transaction silently.
               if (!data_req_i) r_state <= IDLE;
               else             r_cnt   <= r_cnt - 4'd1;
            end
            default: begin
               // Only reached with a request when WAIT_CYCLES > 0.
               if (data_req_i) begin
                  r_cnt   <= 4'(WAIT_CYCLES - 1);
                  r_state <= WAIT;
               end else begin
                  r_state <= IDLE;
               end
            end
         endcase
      end
   end

   assign data_gnt_o    = w_gnt;
   assign data_rvalid_o = (r_state == RESP);
   assign data_rdata_o  = data_rvalid_o ? (r_src_ram ? w_ram_rdata : r_mb_rdata) : 32'd0;
   assign data_err_o    = data_rvalid_o && r_err;
   assign mem_flag_o    = r_flag;
   assign mem_result_o  = r_result;

endmodule

// File: tb/tb_soc_data_responder.sv
module tb_soc_data_responder;
   import soc_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req3, we;
   logic [31:0] addr, wdata;
   logic [3:0]  be;

   logic        gnt0, rv0, err0, gnt3, rv3, err3;
   logic [31:0] rd0, flag0, res0, rd3, flag3, res3;

   int total = 0;
   int bad   = 0;

   logic [32:0] sb_q[$];   // {err, rdata} expected for dut0 responses
   logic        prev_gnt0 = 1'b0;

   always #5 clk = ~clk;

   soc_data_responder #(.WAIT_CYCLES(0)) dut0 (
      .clk_i(clk), .rst_i(rst), .data_req_i(req0), .data_addr_i(addr),
      .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
      .data_gnt_o(gnt0), .data_rvalid_o(rv0), .data_rdata_o(rd0),
      .data_err_o(err0), .mem_flag_o(flag0), .mem_result_o(res0)
   );

   soc_data_responder #(.WAIT_CYCLES(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .data_req_i(req3), .data_addr_i(addr),
      .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
      .data_gnt_o(gnt3), .data_rvalid_o(rv3), .data_rdata_o(rd3),
      .data_err_o(err3), .mem_flag_o(flag3), .mem_result_o(res3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard side for dut0: every rvalid pops one expected response and
   // must follow a grant by exactly one cycle.
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst) begin
         prev_gnt0 = 1'b0;
      end else begin
         if (rv0 || prev_gnt0) chk("rvalid0_after_gnt", 32'(rv0), 32'(prev_gnt0));
         if (rv0) begin
            if (sb_q.size() == 0) chk("sb_unexpected_rvalid", 32'(rv0), 32'd0);
            else begin
               e = sb_q.pop_front();
               chk("sb_rdata0", rd0, e[31:0]);
               chk("sb_err0", 32'(err0), 32'(e[32]));
            end
         end
         prev_gnt0 = gnt0;
      end
   end

   task automatic txn0(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
      sb_q.push_back({exp_err, exp_rd});
      req0 = 1'b1; we = w; addr = a; be = b; wdata = d;
      @(negedge clk);
      chk("gnt0_same_cycle", 32'(gnt0), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic idle0();
      req0 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic txn3(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic [31:0] exp_rd);
      req3 = 1'b1; we = w; addr = a; be = b; wdata = d;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("gnt3_before_cycle3", 32'(gnt3), 32'd0);
         chk("rv3_before_cycle3", 32'(rv3), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("gnt3_cycle3", 32'(gnt3), 32'd1);
      @(posedge clk); #1;
      req3 = 1'b0;
      @(negedge clk);
      chk("rv3_cycle4", 32'(rv3), 32'd1);
      chk("rdata3", rd3, exp_rd);
      chk("err3", 32'(err3), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req0 = 1'b0; req3 = 1'b0; we = 1'b0;
      addr = 32'd0; wdata = 32'd0; be = 4'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt0", 32'(gnt0), 32'd0);
      chk("rst_rv0", 32'(rv0), 32'd0);
      chk("rst_rd0", rd0, 32'd0);
      chk("rst_err0", 32'(err0), 32'd0);
      chk("rst_flag0", flag0, 32'd0);
      chk("rst_res0", res0, 32'd0);
      chk("rst_rv3", 32'(rv3), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic write then read, read issued in the write's RESP cycle
      txn0(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'd0, 1'b0);
      txn0(1'b0, 32'h10, 4'h0, 32'd0, 32'hDEAD_BEEF, 1'b0);
      idle0();

      // Byte lanes
      txn0(1'b1, 32'h20, 4'hF, 32'h1122_3344, 32'd0, 1'b0);
      txn0(1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, 32'd0, 1'b0);
      txn0(1'b0, 32'h22, 4'h0, 32'd0, 32'h11BB_33DD, 1'b0);
      idle0();

      // Back-to-back writes then four back-to-back reads
      for (int i = 0; i < 4; i++)
         txn0(1'b1, 32'h100 + 32'(4*i), 4'hF, 32'hA0B0_C000 + 32'(i), 32'd0, 1'b0);
      for (int i = 0; i < 4; i++)
         txn0(1'b0, 32'h100 + 32'(4*i), 4'hF, 32'd0, 32'hA0B0_C000 + 32'(i), 1'b0);
      idle0();

      // Mailboxes
      txn0(1'b1, DEF_RESULT_ADDR, 4'hF, 32'd55, 32'd0, 1'b0);
      req0 = 1'b0;
      @(negedge clk);
      chk("result_in_resp", res0, 32'd55);
      @(posedge clk); #1;
      txn0(1'b1, DEF_FLAG_ADDR, 4'hF, 32'd1, 32'd0, 1'b0);
      req0 = 1'b0;
      @(negedge clk);
      chk("flag_in_resp", flag0, 32'd1);
      @(posedge clk); #1;
      txn0(1'b0, DEF_FLAG_ADDR, 4'hF, 32'd0, 32'd1, 1'b0);
      txn0(1'b1, DEF_FLAG_ADDR, 4'h0, 32'hFFFF_FFFF, 32'd0, 1'b0);
      txn0(1'b0, DEF_FLAG_ADDR, 4'h0, 32'd0, 32'd1, 1'b0);
      txn0(1'b1, DEF_RESULT_ADDR, 4'b0010, 32'h0000_AB00, 32'd0, 1'b0);
      txn0(1'b0, DEF_RESULT_ADDR, 4'h0, 32'd0, 32'h0000_AB37, 1'b0);
      idle0();

      // Out of range
      txn0(1'b0, 32'h8000_0000, 4'hF, 32'd0, 32'd0, 1'b1);
      txn0(1'b1, 32'h0002_0000, 4'hF, 32'h1234_5678, 32'd0, 1'b1);
      txn0(1'b0, 32'h20, 4'hF, 32'd0, 32'h11BB_33DD, 1'b0);
      idle0();

      // Wait states
      txn3(1'b0, DEF_RESULT_ADDR, 4'hF, 32'd0, 32'd0);
      req3 = 1'b1; we = 1'b0; addr = 32'h40;
      @(posedge clk); #1;
      req3 = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("drop_gnt3", 32'(gnt3), 32'd0);
         chk("drop_rv3", 32'(rv3), 32'd0);
      end
      @(posedge clk); #1;
      txn3(1'b1, DEF_FLAG_ADDR, 4'hF, 32'd5, 32'd0);
      chk("flag3_written", flag3, 32'd5);
      txn3(1'b1, 32'h40, 4'hF, 32'hCAFE_F00D, 32'd0);
      txn3(1'b0, 32'h40, 4'h0, 32'd0, 32'hCAFE_F00D);

      // Reset during WAIT
      req3 = 1'b1; we = 1'b0; addr = 32'h40;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("midrst_gnt3", 32'(gnt3), 32'd0);
      chk("midrst_rv3", 32'(rv3), 32'd0);
      chk("midrst_rd3", rd3, 32'd0);
      chk("midrst_err3", 32'(err3), 32'd0);
      chk("midrst_flag3", flag3, 32'd0);
      chk("midrst_res3", res3, 32'd0);
      chk("midrst_flag0", flag0, 32'd0);
      chk("midrst_res0", res0, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      req3 = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("postrst_rv3", 32'(rv3), 32'd0);
      end

      repeat (2) @(posedge clk);
      #1;
      chk("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
